fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-bit, 16-deep sync FIFO stage.
- Pops bytes from the FIFO while it is non-empty and serialises each one onto a UART line.
- Frame: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
- Sits between the FIFO read port and the board-level tx pin.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit period; legal values are 2 or more.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tx_en  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  8  FIFO read data; valid the cycle after a FIFO read is accepted.
- fifo_rd  output  1  FIFO read strobe; asserted for exactly one cycle per byte.
- tx  output  1  serial line; idles high.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Reset values: tx=1, fifo_rd=0, busy=0, tx_done=0, state=IDLE, all counters 0.
- FIFO contract: a read is accepted when fifo_rd=1 and fifo_empty=0 at a posedge. fifo_dout updates at that same edge. This block is the FIFO's only reader.
- State machine:
  - IDLE: if tx_en=1 and fifo_empty=0, go to FETCH; otherwise stay.
  - FETCH: fifo_rd=1, decoded from the registered state. Go to LATCH after 1 cycle.
  - LATCH: fifo_dout is captured into the shift register at the end of the cycle. Parity is captured as the XOR of the byte. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = shift[0]; the register shifts right every CLKS_PER_BIT cycles. After 8 bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = even-parity bit for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 on the final cycle, then return to IDLE.
- tx is a registered output and changes together with the state register.
- Latency: tx falls 3 clks after the first IDLE cycle in which tx_en=1 and fifo_empty=0.
- Back-to-back frames: the idle-high gap between a stop bit and the next start bit is exactly 3 clks (IDLE, FETCH, LATCH).
- Baud counter:
  - width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - cleared on every state entry.
- Bit counter: 3 bits, counts 0..7 in DATA.
- tx_en deasserted mid-frame: the frame completes; no new frame starts until tx_en=1 again.
- fifo_empty is ignored outside IDLE.
- Reset mid-frame: the next edge returns to IDLE with tx=1. The popped byte is discarded and not re-read.
- Reset during FETCH: the FIFO read still completes if the FIFO is not in reset. The byte is lost, which is acceptable.

Decomposition:
- Package fifo_uart_pkg:
  - typedef enum state_t {IDLE, FETCH, LATCH, START, DATA, PARITY, STOP};
  - localparam DATA_W=8;
  - function frame_bits(PARITY_EN, STOP_BITS) = 1+8+PARITY_EN+STOP_BITS.
- Sub-module uart_baud_gen:
  - inputs: clk, rst, clear.
  - output: bit_tick, high on count CLKS_PER_BIT-1.
  - the FSM consumes bit_tick.

Test Plan:
- Reset, CLKS_PER_BIT=4, FIFO empty, tx_en=1, 50 clks -> tx=1, busy=0, fifo_rd never asserted.
- Push 0xA5, tx_en=1 -> fifo_rd single pulse; tx falls 3 clks later; 4-clk bit sequence 0,1,0,1,0,0,1,0,1,1; tx_done pulse on final stop cycle; FIFO empty afterwards.
- PARITY_EN=1, STOP_BITS=2, byte 0x07 -> parity bit 1; stop high for 8 clks; total frame 48 clks.
- Push 0x55 then 0xAA back-to-back -> two frames separated by exactly 3 high clks; fifo_rd pulsed exactly twice; decoded bytes 0x55, 0xAA in order.
- 3 bytes queued, tx_en dropped during frame 1 DATA -> frame 1 completes; no further fifo_rd until tx_en=1; then bytes 2 and 3 are sent.
- rst asserted during the 4th data bit of 0xF0 -> next cycle tx=1, busy=0, fifo_rd=0; next queued byte sent intact after release.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Holds the frame state encoding, the data width and the frame length and parity helpers.
package fifo_uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LATCH  = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    // Number of bit periods in one frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int parity_en, input int stop_bits);
        return 1 + DATA_W + parity_en + stop_bits;
    endfunction

    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Bundle of FIFO read-port, enable and serial-line signals around the UART transmitter.
// The transmitter uses the master view; the FIFO/board side uses the slave view.
interface fifo_uart_tx_if;
    import fifo_uart_pkg::*;

    logic              tx_en;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd;
    logic              tx;
    logic              busy;
    logic              tx_done;

    modport master (
        input  tx_en,
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd,
        output tx,
        output busy,
        output tx_done
    );

    modport slave (
        output tx_en,
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd,
        input  tx,
        input  busy,
        input  tx_done
    );

endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last and second-to-last cycle.
// The early flag lets the transmitter register its end-of-frame pulse onto the final cycle.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick,
    output logic bit_pre_tick
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Baud counter: held at zero while cleared, wraps at each bit boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= ZERO;
        end else if (clear) begin
            cnt_r <= ZERO;
        end else if (cnt_r == LAST) begin
            cnt_r <= ZERO;
        end else begin
            cnt_r <= cnt_r + ONE;
        end
    end

    // Boundary decode of the counter.
    always_comb begin
        bit_tick     = (cnt_r == LAST);
        bit_pre_tick = (cnt_r == PRE_LAST);
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one byte per frame and serialises it LSB first
// with a start bit, optional even parity and one or two stop bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_uart_tx_if.master        bus
);

    localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    state_t            state_r;
    logic [DATA_W-1:0] shift_r;
    logic              parity_r;
    logic [2:0]        bit_cnt_r;
    logic              stop_cnt_r;
    logic              tx_r;
    logic              rd_r;
    logic              busy_r;
    logic              done_r;

    logic              baud_clear_s;
    logic              bit_tick_s;
    logic              bit_pre_tick_s;
    logic              last_stop_s;

    // The bit timer only runs in the line-driving states, so it starts every frame at zero.
    always_comb begin
        baud_clear_s = (state_r == IDLE) || (state_r == FETCH) || (state_r == LATCH);
        last_stop_s  = (stop_cnt_r == LAST_STOP);
    end

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk          (clk),
        .rst          (rst),
        .clear        (baud_clear_s),
        .bit_tick     (bit_tick_s),
        .bit_pre_tick (bit_pre_tick_s)
    );

    // Frame state machine; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= 8'h00;
            parity_r   <= 1'b0;
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
            rd_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.tx_en && !bus.fifo_empty) begin
                        state_r <= FETCH;
                        rd_r    <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                FETCH: begin
                    state_r <= LATCH;
                    rd_r    <= 1'b0;
                end
                LATCH: begin
                    shift_r   <= bus.fifo_dout;
                    parity_r  <= even_parity(bus.fifo_dout);
                    bit_cnt_r <= 3'd0;
                    state_r   <= START;
                    tx_r      <= 1'b0;
                end
                START: begin
                    if (bit_tick_s) begin
                        state_r <= DATA;
                        tx_r    <= shift_r[0];
                    end
                end
                DATA: begin
                    if (bit_tick_s) begin
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_r <= 3'd0;
                            if (PARITY_EN != 0) begin
                                state_r <= PARITY;
                                tx_r    <= parity_r;
                            end else begin
                                state_r    <= STOP;
                                tx_r       <= 1'b1;
                                stop_cnt_r <= 1'b0;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
                            tx_r      <= shift_r[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick_s) begin
                        state_r    <= STOP;
                        tx_r       <= 1'b1;
                        stop_cnt_r <= 1'b0;
                    end
                end
                STOP: begin
                    // Raise done one cycle early so it lands on the final stop cycle.
                    if (bit_pre_tick_s && last_stop_s) begin
                        done_r <= 1'b1;
                    end
                    if (bit_tick_s) begin
                        if (last_stop_s) begin
                            state_r    <= IDLE;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b0;
                            stop_cnt_r <= 1'b0;
                        end else begin
                            stop_cnt_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                    rd_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_rd = rd_r;
    assign bus.tx      = tx_r;
    assign bus.busy    = busy_r;
    assign bus.tx_done = done_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two configurations (8N1 and 8E2, 4 clks/bit) share one stimulus
// stream and are each compared cycle by cycle against a frame-waveform reference model.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    localparam int CPB = 4;

    typedef struct packed {
        logic tx;
        logic busy;
        logic rd;
        logic done;
    } exp_t;

    localparam exp_t IDLE_E = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       push_valid;
    logic [7:0] push_byte;

    int n_checks = 0;
    int n_fail   = 0;

    logic busy_w  [2];
    logic tx_w    [2];
    logic fe_w    [2];
    int   rd_cnt_w[2];
    int   start_w [2];
    int   fsize_w [2];

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int PEN = g;
        localparam int SB  = g + 1;

        fifo_uart_tx_if bus();

        byte unsigned fq[$];
        byte unsigned mq[$];
        exp_t         wq[$];
        int           rd_cnt = 0;
        int           starts = 0;
        int           fsz    = 0;

        assign bus.tx_en = tx_en;
        assign busy_w[g]   = bus.busy;
        assign tx_w[g]     = bus.tx;
        assign fe_w[g]     = bus.fifo_empty;
        assign rd_cnt_w[g] = rd_cnt;
        assign start_w[g]  = starts;
        assign fsize_w[g]  = fsz;

        fifo_uart_tx #(
            .CLKS_PER_BIT (CPB),
            .PARITY_EN    (PEN),
            .STOP_BITS    (SB)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // FIFO environment plus reference model: each accepted start appends the whole
        // expected frame waveform (fetch, latch, bit periods, idle) to a queue.
        initial begin
            exp_t        cur;
            logic [11:0] fr;
            byte unsigned b;
            int          nb;
            forever begin
                @(posedge clk);
                if (bus.fifo_rd) rd_cnt++;
                if (bus.fifo_rd && !bus.fifo_empty && fq.size() != 0) begin
                    bus.fifo_dout <= fq[0];
                    fq.delete(0);
                end
                if (push_valid) begin
                    fq.push_back(push_byte);
                    mq.push_back(push_byte);
                end
                bus.fifo_empty <= (fq.size() == 0);
                fsz = fq.size();

                if (rst) begin
                    wq.delete();
                    cur = IDLE_E;
                end else if (wq.size() != 0) begin
                    cur = wq.pop_front();
                end else begin
                    cur = IDLE_E;
                    if (tx_en && bus.fifo_empty === 1'b0 && mq.size() != 0) begin
                        b  = mq.pop_front();
                        starts++;
                        nb = frame_bits(PEN, SB);
                        fr = 12'hFFF;
                        fr[0]   = 1'b0;
                        fr[8:1] = b;
                        if (PEN != 0) fr[9] = ^b;
                        wq.push_back(exp_t'(4'b1110));
                        wq.push_back(exp_t'(4'b1100));
                        for (int i = 0; i < nb; i++) begin
                            for (int j = 0; j < CPB; j++) begin
                                wq.push_back('{tx: fr[i], busy: 1'b1, rd: 1'b0,
                                               done: (i == nb - 1 && j == CPB - 1)});
                            end
                        end
                        wq.push_back(IDLE_E);
                        cur = wq.pop_front();
                    end
                end

                #1;
                chk_val($sformatf("cfg%0d_tx", g),      32'(bus.tx),      32'(cur.tx));
                chk_val($sformatf("cfg%0d_busy", g),    32'(bus.busy),    32'(cur.busy));
                chk_val($sformatf("cfg%0d_fifo_rd", g), 32'(bus.fifo_rd), 32'(cur.rd));
                chk_val($sformatf("cfg%0d_tx_done", g), 32'(bus.tx_done), 32'(cur.done));
            end
        end
    end

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        push_valid = 1'b1;
        push_byte  = b;
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int n = 0; n < 20000 && quiet < 4; n++) begin
            @(negedge clk);
            if (!busy_w[0] && !busy_w[1] && fe_w[0] && fe_w[1]) quiet++;
            else quiet = 0;
        end
        chk_val("wait_idle_timeout", 32'(quiet >= 4), 32'd1);
    endtask

    task automatic wait_tx_low();
        int seen = 0;
        for (int n = 0; n < 200 && seen == 0; n++) begin
            @(negedge clk);
            if (tx_w[0] == 1'b0) seen = 1;
        end
        chk_val("wait_tx_low_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        tx_en      = 1'b0;
        push_valid = 1'b0;
        push_byte  = 8'h00;
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        tx_en = 1'b1;

        // Empty FIFO with tx enabled: nothing may happen.
        repeat (50) @(negedge clk);
        chk_val("empty_no_rd_cfg0", 32'(rd_cnt_w[0]), 32'd0);
        chk_val("empty_no_rd_cfg1", 32'(rd_cnt_w[1]), 32'd0);

        push(8'hA5);
        wait_idle();
        chk_val("a5_single_rd_cfg0", 32'(rd_cnt_w[0]), 32'd1);
        chk_val("a5_single_rd_cfg1", 32'(rd_cnt_w[1]), 32'd1);

        push(8'h07);
        wait_idle();

        push(8'h55);
        push(8'hAA);
        wait_idle();
        chk_val("b2b_rd_cfg0", 32'(rd_cnt_w[0]), 32'd4);
        chk_val("b2b_rd_cfg1", 32'(rd_cnt_w[1]), 32'd4);

        // tx_en dropped mid-frame: the frame finishes and the rest stays queued.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_tx_low();
        repeat (6) @(negedge clk);
        tx_en = 1'b0;
        repeat (200) @(negedge clk);
        chk_val("hold_rd_cfg0", 32'(rd_cnt_w[0]), 32'd5);
        chk_val("hold_rd_cfg1", 32'(rd_cnt_w[1]), 32'd5);
        chk_val("hold_queued_cfg0", 32'(fsize_w[0]), 32'd2);
        chk_val("hold_queued_cfg1", 32'(fsize_w[1]), 32'd2);
        tx_en = 1'b1;
        wait_idle();

        // Reset during the fourth data bit of 0xF0; 0x3C must follow intact.
        push(8'hF0);
        push(8'h3C);
        wait_tx_low();
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_val("rst_tx_high", 32'(tx_w[0]), 32'd1);
        chk_val("rst_busy_low", 32'(busy_w[0]), 32'd0);
        wait_idle();

        // Random traffic with occasional enable toggles and resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            push_valid = ($urandom_range(0, 99) < 2);
            push_byte  = 8'($urandom);
            if ($urandom_range(0, 199) == 0) tx_en = ~tx_en;
            rst = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        push_valid = 1'b0;
        rst        = 1'b0;
        tx_en      = 1'b1;
        wait_idle();

        for (int g = 0; g < 2; g++) begin
            chk_val($sformatf("final_rd_vs_starts_cfg%0d", g), 32'(rd_cnt_w[g]), 32'(start_w[g]));
            chk_val($sformatf("final_fifo_drained_cfg%0d", g), 32'(fsize_w[g]), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
